// File: rtl/sgd_predict_if.sv
// sgd_predict_if: handshake/bus bundle between a row/weight source and the
// sgd_predict inference stage.
//   w_load/w_data    : weight latch strobe and packed 16-word weight vector
//   feat/x_valid/x_ready/x_data : feature row stream (y in the top word)
//   y_valid/y_ready/y_cap/err   : result stream (prediction and residual)
// master = source/sink side, slave = sgd_predict side.
interface sgd_predict_if #(
  parameter int unsigned LENGTH       = 16,
  parameter int unsigned MAX_FEATURES = 15,
  parameter int unsigned DATA_WIDTH   = LENGTH * (MAX_FEATURES + 1)
);
  logic                  w_load;
  logic [DATA_WIDTH-1:0] w_data;
  logic [3:0]            feat;
  logic                  x_valid;
  logic                  x_ready;
  logic [DATA_WIDTH-1:0] x_data;
  logic                  y_valid;
  logic                  y_ready;
  logic [LENGTH-1:0]     y_cap;
  logic [LENGTH-1:0]     err;

  modport master (
    output w_load, w_data, feat, x_valid, x_data, y_ready,
    input  x_ready, y_valid, y_cap, err
  );

  modport slave (
    input  w_load, w_data, feat, x_valid, x_data, y_ready,
    output x_ready, y_valid, y_cap, err
  );
endinterface

// File: rtl/sgd_predict.sv
// sgd_predict: inference stage behind the SGD trainer. Latches the packed
// weight vector on w_load, then for each accepted feature row runs a
// LANES-wide Q7.8 MAC over ceil(feat/LANES) cycles and presents the
// saturated prediction y_cap and residual err = y - y_cap.
// Ports:
//   CLK      : clock, rising edge
//   RST      : synchronous active-high reset
//   bus      : sgd_predict_if.slave (weights, row stream, result stream)
//   w_loaded : weights have been loaded since reset
//   busy     : high while in MAC or OUT
module sgd_predict #(
  parameter int unsigned LENGTH       = 16,
  parameter int unsigned MAX_FEATURES = 15,
  parameter int unsigned DATA_WIDTH   = LENGTH * (MAX_FEATURES + 1),
  parameter int unsigned FRAC         = 8,
  parameter int unsigned LANES        = 3
) (
  input  logic          CLK,
  input  logic          RST,
  sgd_predict_if.slave  bus,
  output logic          w_loaded,
  output logic          busy
);
  localparam int unsigned NW    = MAX_FEATURES + 1;
  localparam int unsigned FW    = $clog2(NW);
  localparam int unsigned ACC_W = LENGTH + 4;
  localparam int unsigned PW    = 2 * LENGTH;

  typedef enum logic [1:0] {S_IDLE, S_READY, S_MAC, S_OUT} state_t;

  state_t                   state_q;
  logic signed [LENGTH-1:0] w_q   [NW];
  logic signed [LENGTH-1:0] row_q [NW];  // row_q[0] holds y, row_q[i] holds x_i
  logic [FW-1:0]            feat_q;
  logic [FW-1:0]            k_q;
  logic [FW-1:0]            g_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic                     y_valid_q;
  logic [LENGTH-1:0]        y_cap_q;
  logic [LENGTH-1:0]        err_q;
  logic                     w_loaded_q;
  logic                     busy_q;

  logic [FW-1:0]            g_d;
  logic [FW:0]              idx;
  logic signed [PW-1:0]     prod;
  logic signed [ACC_W-1:0]  lane_sum;
  logic signed [ACC_W-1:0]  acc_d;
  logic signed [ACC_W-1:0]  fin_acc;
  logic signed [LENGTH-1:0] y_src;
  logic signed [LENGTH-1:0] y_cap_d;
  logic signed [LENGTH-1:0] err_d;

  // Saturate a PW-bit signed value to LENGTH bits: it fits only when all
  // bits from the LENGTH-1 sign position upward agree.
  function automatic logic signed [LENGTH-1:0] sat(input logic signed [PW-1:0] v);
    if (v[PW-1:LENGTH-1] == '0 || v[PW-1:LENGTH-1] == '1)
      return v[LENGTH-1:0];
    else if (v[PW-1])
      return {1'b1, {(LENGTH-1){1'b0}}};
    else
      return {1'b0, {(LENGTH-1){1'b1}}};
  endfunction

  assign g_d = FW'((32'(bus.feat) + LANES - 1) / LANES);

  // One MAC cycle: lanes cover features LANES*k+1 .. LANES*k+LANES; slots
  // beyond feat_q contribute nothing.
  always_comb begin
    lane_sum = '0;
    idx      = '0;
    prod     = '0;
    for (int unsigned j = 0; j < LANES; j++) begin
      idx  = (FW+1)'(LANES * k_q + j + 1);
      prod = '0;
      if (idx <= {1'b0, feat_q})
        prod = row_q[idx[FW-1:0]] * w_q[idx[FW-1:0]];
      lane_sum = lane_sum + ACC_W'(sat(prod >>> FRAC));
    end
  end

  // Result path is shared: with feat=0 the answer is formed straight from
  // W0 and the incoming y at accept time; otherwise from the final MAC sum.
  always_comb begin
    acc_d   = acc_q + lane_sum;
    fin_acc = (state_q == S_READY) ? ACC_W'(w_q[0]) : acc_d;
    y_src   = (state_q == S_READY) ? bus.x_data[DATA_WIDTH-1 -: LENGTH] : row_q[0];
    y_cap_d = sat(PW'(fin_acc));
    err_d   = sat(PW'(y_src) - PW'(y_cap_d));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      for (int unsigned i = 0; i < NW; i++) begin
        w_q[i]   <= '0;
        row_q[i] <= '0;
      end
      feat_q     <= '0;
      k_q        <= '0;
      g_q        <= '0;
      acc_q      <= '0;
      y_valid_q  <= 1'b0;
      y_cap_q    <= '0;
      err_q      <= '0;
      w_loaded_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.w_load) begin
            for (int unsigned i = 0; i < NW; i++)
              w_q[i] <= bus.w_data[DATA_WIDTH-1-LENGTH*i -: LENGTH];
            w_loaded_q <= 1'b1;
            state_q    <= S_READY;
          end
        end
        S_READY: begin
          if (bus.w_load) begin
            for (int unsigned i = 0; i < NW; i++)
              w_q[i] <= bus.w_data[DATA_WIDTH-1-LENGTH*i -: LENGTH];
          end else if (bus.x_valid) begin
            for (int unsigned i = 0; i < NW; i++)
              row_q[i] <= bus.x_data[DATA_WIDTH-1-LENGTH*i -: LENGTH];
            feat_q <= bus.feat;
            g_q    <= g_d;
            k_q    <= '0;
            acc_q  <= ACC_W'(w_q[0]);
            busy_q <= 1'b1;
            if (g_d == '0) begin
              state_q   <= S_OUT;
              y_valid_q <= 1'b1;
              y_cap_q   <= y_cap_d;
              err_q     <= err_d;
            end else begin
              state_q   <= S_MAC;
            end
          end
        end
        S_MAC: begin
          acc_q <= acc_d;
          k_q   <= k_q + FW'(1);
          if (k_q == g_q - FW'(1)) begin
            state_q   <= S_OUT;
            y_valid_q <= 1'b1;
            y_cap_q   <= y_cap_d;
            err_q     <= err_d;
          end
        end
        S_OUT: begin
          if (bus.y_ready) begin
            state_q   <= S_READY;
            y_valid_q <= 1'b0;
            busy_q    <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.x_ready = (state_q == S_READY) && !bus.w_load;
  assign bus.y_valid = y_valid_q;
  assign bus.y_cap   = y_cap_q;
  assign bus.err     = err_q;
  assign w_loaded    = w_loaded_q;
  assign busy        = busy_q;
endmodule

// File: tb/tb_sgd_predict.sv
// tb_sgd_predict: directed bench for sgd_predict. A table of weight/row
// vectors with hand-computed predictions, residuals and latencies, plus
// sequences for backpressure, weight guard, load priority and reset.
module tb_sgd_predict;
  logic clk;
  logic rst;
  logic w_loaded;
  logic busy;

  sgd_predict_if bus ();

  sgd_predict dut (
    .CLK      (clk),
    .RST      (rst),
    .bus      (bus.slave),
    .w_loaded (w_loaded),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [255:0] w;
    logic [255:0] x;
    logic [3:0]   feat;
    logic [15:0]  ycap;
    logic [15:0]  err;
    int           lat;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];

  function automatic logic [255:0] rep16(input logic [15:0] v);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[255-16*i -: 16] = v;
    return r;
  endfunction

  function automatic logic [255:0] setw(input logic [255:0] d, input int i, input logic [15:0] v);
    logic [255:0] r;
    r = d;
    r[255-16*i -: 16] = v;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic load_w(input logic [255:0] w);
    @(negedge clk);
    bus.w_load = 1'b1;
    bus.w_data = w;
    @(negedge clk);
    bus.w_load = 1'b0;
  endtask

  // Present a row, wait for acceptance, then count cycles until y_valid.
  // Optionally pulses w_load on the first cycle after acceptance.
  task automatic run_row(input logic [255:0] x, input logic [3:0] f,
                         input logic do_wl, input logic [255:0] wl, output int lat);
    int n;
    bus.x_valid = 1'b1;
    bus.x_data  = x;
    bus.feat    = f;
    #1;
    n = 0;
    while (!bus.x_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!bus.x_ready) begin
      checks++;
      errors++;
      $display("FAIL x_ready_wait: got timeout expected x_ready");
    end
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        bus.x_valid = 1'b0;
        if (do_wl) begin
          bus.w_load = 1'b1;
          bus.w_data = wl;
        end
      end else if (lat == 2) begin
        bus.w_load = 1'b0;
      end
    end while (!bus.y_valid && lat < 20);
    bus.w_load = 1'b0;
  endtask

  task automatic consume(input string nm);
    @(negedge clk);
    bus.y_ready = 1'b1;
    @(negedge clk);
    bus.y_ready = 1'b0;
    chk({nm, "_yvalid_after"}, 32'(bus.y_valid), 32'd0);
    chk({nm, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [255:0] w0, x0, wsat, xsat;
    bit yv_seen;

    w0   = setw(setw('0, 0, 16'h0100), 1, 16'h0200);
    x0   = setw(setw('0, 0, 16'h0800), 1, 16'h0300);
    wsat = setw(setw(setw('0, 1, 16'h7F00), 2, 16'h7F00), 3, 16'h7F00);
    xsat = wsat;

    vecs[0] = '{w0, x0, 4'd1, 16'h0700, 16'h0100, 2};
    vecs[1] = '{rep16(16'h0100), rep16(16'h0100), 4'd15, 16'h1000, 16'hF100, 6};
    vecs[2] = '{rep16(16'h0100), rep16(16'h0100), 4'd0, 16'h0100, 16'h0000, 1};
    vecs[3] = '{rep16(16'h0100),
                setw(setw(setw(setw(setw(rep16(16'h7FFF), 0, 16'h0000), 1, 16'h0100),
                     2, 16'h0100), 3, 16'h0100), 4, 16'h0100),
                4'd4, 16'h0500, 16'hFB00, 3};
    vecs[4] = '{wsat, xsat, 4'd3, 16'h7FFF, 16'h8001, 2};
    vecs[5] = '{wsat, setw(xsat, 0, 16'h8000), 4'd3, 16'h7FFF, 16'h8000, 2};
    vecs[6] = '{setw('0, 1, 16'hFF00), setw('0, 1, 16'h0200), 4'd1, 16'hFE00, 16'h0200, 2};
    vecs[7] = '{setw('0, 1, 16'h8000), setw(setw('0, 0, 16'h7FFF), 1, 16'h7F00),
                4'd1, 16'h8000, 16'h7FFF, 2};
    vecs[8] = '{rep16(16'h0100), setw(rep16(16'h0100), 0, 16'h0300), 4'd2, 16'h0300, 16'h0000, 2};

    rst         = 1'b1;
    bus.w_load  = 1'b0;
    bus.w_data  = '0;
    bus.feat    = '0;
    bus.x_valid = 1'b0;
    bus.x_data  = '0;
    bus.y_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_x_ready", 32'(bus.x_ready), 32'd0);
    chk("rst_y_valid", 32'(bus.y_valid), 32'd0);
    chk("rst_y_cap", 32'(bus.y_cap), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_w_loaded", 32'(w_loaded), 32'd0);

    // No weights yet: a pending row must not be accepted.
    bus.x_valid = 1'b1;
    bus.x_data  = x0;
    bus.feat    = 4'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("idle_x_ready_%0d", i), 32'(bus.x_ready), 32'd0);
    end
    chk("idle_busy", 32'(busy), 32'd0);
    bus.x_valid = 1'b0;

    for (int i = 0; i < NV; i++) begin
      load_w(vecs[i].w);
      if (i == 0) chk("w_loaded_set", 32'(w_loaded), 32'd1);
      run_row(vecs[i].x, vecs[i].feat, 1'b0, '0, lat);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d_y_cap", i), 32'(bus.y_cap), 32'(vecs[i].ycap));
      chk($sformatf("v%0d_err", i), 32'(bus.err), 32'(vecs[i].err));
      consume($sformatf("v%0d", i));
    end

    // Backpressure: result held while y_ready is low.
    load_w(w0);
    run_row(x0, 4'd1, 1'b0, '0, lat);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("bp_y_cap_%0d", i), 32'(bus.y_cap), 32'h0700);
      chk($sformatf("bp_err_%0d", i), 32'(bus.err), 32'h0100);
      chk($sformatf("bp_y_valid_%0d", i), 32'(bus.y_valid), 32'd1);
      chk($sformatf("bp_x_ready_%0d", i), 32'(bus.x_ready), 32'd0);
    end
    chk("bp_busy", 32'(busy), 32'd1);
    consume("bp");
    #1;
    chk("bp_x_ready_after", 32'(bus.x_ready), 32'd1);

    // Weight guard: a load pulsed during MAC is dropped entirely.
    load_w(rep16(16'h0100));
    run_row(rep16(16'h0100), 4'd15, 1'b1, rep16(16'h0200), lat);
    chk("guard_lat", 32'(lat), 32'd6);
    chk("guard_y_cap", 32'(bus.y_cap), 32'h1000);
    consume("guard");
    run_row(rep16(16'h0100), 4'd15, 1'b0, '0, lat);
    chk("guard_next_y_cap", 32'(bus.y_cap), 32'h1000);
    consume("guard_next");

    // Load priority: w_load and x_valid together in READY.
    @(negedge clk);
    bus.w_load  = 1'b1;
    bus.w_data  = rep16(16'h0200);
    bus.x_valid = 1'b1;
    bus.x_data  = setw('0, 1, 16'h0100);
    bus.feat    = 4'd1;
    #1;
    chk("prio_x_ready_load", 32'(bus.x_ready), 32'd0);
    @(negedge clk);
    bus.w_load = 1'b0;
    #1;
    chk("prio_x_ready_next", 32'(bus.x_ready), 32'd1);
    run_row(setw('0, 1, 16'h0100), 4'd1, 1'b0, '0, lat);
    chk("prio_lat", 32'(lat), 32'd2);
    chk("prio_y_cap", 32'(bus.y_cap), 32'h0400);
    chk("prio_err", 32'(bus.err), 32'hFC00);
    consume("prio");

    // Reset in the middle of a MAC sequence.
    @(negedge clk);
    bus.x_valid = 1'b1;
    bus.x_data  = rep16(16'h0100);
    bus.feat    = 4'd15;
    @(posedge clk);
    @(negedge clk);
    bus.x_valid = 1'b0;
    chk("mac_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_y_valid", 32'(bus.y_valid), 32'd0);
    chk("mrst_y_cap", 32'(bus.y_cap), 32'd0);
    chk("mrst_err", 32'(bus.err), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_w_loaded", 32'(w_loaded), 32'd0);
    chk("mrst_x_ready", 32'(bus.x_ready), 32'd0);
    bus.x_valid = 1'b1;
    yv_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.y_valid || bus.x_ready) yv_seen = 1'b1;
    end
    chk("mrst_quiet", 32'(yv_seen), 32'd0);
    bus.x_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
